// File: rtl/noise_gate.sv
// Envelope-following noise gate: peak envelope, attack/hold/release gain FSM with
// hysteresis, Q1.15 gain applied to each accepted sample with one cycle of latency.
module noise_gate #(
  parameter int width        = 16,
  parameter int hold_width   = 16,
  parameter int attack_step  = 1024,
  parameter int release_step = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [width-1:0] in_signal,
  input  logic [width-1:0]        thresh_open,
  input  logic [width-1:0]        thresh_close,
  input  logic [hold_width-1:0]   hold_len,
  input  logic [3:0]              decay_shift,
  input  logic                    bypass,
  output logic signed [width-1:0] out_signal,
  output logic                    out_valid,
  output logic                    gate_open
);

  localparam int GW = width + 1;
  localparam int PW = width + GW + 1;
  localparam logic [GW-1:0]    UNITY = {2'b01, {(width-1){1'b0}}};
  localparam logic [GW-1:0]    ATK   = GW'(attack_step);
  localparam logic [GW-1:0]    REL   = GW'(release_step);
  localparam logic [width-1:0] AMAX  = {1'b0, {(width-1){1'b1}}};
  localparam logic [hold_width-1:0] CNT_ONE = hold_width'(1);

  typedef enum logic [2:0] {
    CLOSED,
    ATTACK,
    OPEN,
    HOLD,
    RELEASE
  } state_t;

  // Magnitude with the most negative code clamped to the largest positive code.
  function automatic logic [width-1:0] abs_sat(input logic signed [width-1:0] x);
    logic [width-1:0] neg;
    neg = ~$unsigned(x) + {{(width-1){1'b0}}, 1'b1};
    if (!x[width-1]) return $unsigned(x);
    if (neg[width-1]) return AMAX;
    return neg;
  endfunction

  function automatic logic [width-1:0] env_follow(input logic [width-1:0] a,
                                                  input logic [width-1:0] env,
                                                  input logic [3:0]       sh);
    logic [width-1:0] dec;
    dec = env - (env >> sh);
    return (a > dec) ? a : dec;
  endfunction

  // Signed sample times unsigned Q1.15 gain, floor-scaled back to sample width.
  function automatic logic signed [width-1:0] scale_q15(input logic signed [width-1:0] x,
                                                        input logic [GW-1:0]          g);
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ge;
    logic signed [PW-1:0] prod;
    xe   = {{(PW-width){x[width-1]}}, x};
    ge   = {{(PW-GW){1'b0}}, g};
    prod = xe * ge;
    return prod[2*width-2 -: width];
  endfunction

  state_t                  state_q, state_d;
  logic [GW-1:0]           gain_q, gain_d;
  logic [width-1:0]        env_q, env_d;
  logic [hold_width-1:0]   cnt_q, cnt_d;
  logic signed [width-1:0] out_q, out_d;
  logic                    vld_q;

  logic [width-1:0]        env_nx;
  logic                    opens;
  logic [GW:0]             atk_sum;

  always_comb begin
    env_nx  = env_follow(abs_sat(in_signal), env_q, decay_shift);
    opens   = (env_nx >= thresh_open);
    atk_sum = {1'b0, gain_q} + {1'b0, ATK};
    state_d = state_q;
    gain_d  = gain_q;
    cnt_d   = cnt_q;
    env_d   = env_q;
    out_d   = out_q;
    if (in_valid) begin
      env_d = env_nx;
      // The product always uses the gain held before this sample's update.
      out_d = bypass ? in_signal : scale_q15(in_signal, gain_q);
      unique case (state_q)
        CLOSED: begin
          gain_d = '0;
          if (opens) state_d = ATTACK;
        end
        ATTACK: begin
          if (atk_sum >= {1'b0, UNITY}) begin
            gain_d  = UNITY;
            state_d = OPEN;
          end else begin
            gain_d = atk_sum[GW-1:0];
          end
        end
        OPEN: begin
          if (env_nx < thresh_close) begin
            if (hold_len == '0) begin
              state_d = RELEASE;
            end else begin
              state_d = HOLD;
              cnt_d   = hold_len;
            end
          end
        end
        HOLD: begin
          if (opens) begin
            state_d = OPEN;
          end else if (cnt_q == CNT_ONE) begin
            state_d = RELEASE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        RELEASE: begin
          // Re-opening mid-release ramps up from the current gain, not from zero.
          if (opens) begin
            state_d = ATTACK;
          end else if (gain_q > REL) begin
            gain_d = gain_q - REL;
          end else begin
            gain_d  = '0;
            state_d = CLOSED;
          end
        end
        default: begin
          state_d = CLOSED;
          gain_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLOSED;
      gain_q  <= '0;
      env_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      env_q   <= env_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= in_valid;
    end
  end

  assign out_signal = out_q;
  assign out_valid  = vld_q;
  assign gate_open  = (state_q != CLOSED);

endmodule

// File: tb/tb_noise_gate.sv
// Bench for noise_gate: directed scenarios plus randomized traffic, all checked
// against an arithmetic reference model of the gate's rules.
module tb_noise_gate;

  localparam int W   = 16;
  localparam int HW  = 16;
  localparam int ATK = 8192;
  localparam int REL = 16384;
  localparam int UNITY = 32768;

  localparam int M_CLOSED  = 0;
  localparam int M_ATTACK  = 1;
  localparam int M_OPEN    = 2;
  localparam int M_HOLD    = 3;
  localparam int M_RELEASE = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic signed [W-1:0] in_signal;
  logic [W-1:0]        thresh_open;
  logic [W-1:0]        thresh_close;
  logic [HW-1:0]       hold_len;
  logic [3:0]          decay_shift;
  logic                bypass;
  logic signed [W-1:0] out_signal;
  logic                out_valid;
  logic                gate_open;

  noise_gate #(
    .width(W),
    .hold_width(HW),
    .attack_step(ATK),
    .release_step(REL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_signal(in_signal),
    .thresh_open(thresh_open),
    .thresh_close(thresh_close),
    .hold_len(hold_len),
    .decay_shift(decay_shift),
    .bypass(bypass),
    .out_signal(out_signal),
    .out_valid(out_valid),
    .gate_open(gate_open)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  int m_env, m_gain, m_cnt, m_st, m_out, m_vld;

  int exp_att[7] = '{0, 0, 1000, 2000, 3000, 4000, 4000};
  int exp_rel[7] = '{200, 200, 200, 200, 200, 100, 0};
  int byp_in[3]  = '{123, -456, 999};

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: one accepted sample or reset, evaluated at the clock edge.
  task automatic model_edge();
    int a, dec, en;
    if (rst) begin
      m_env = 0; m_gain = 0; m_cnt = 0; m_st = M_CLOSED; m_out = 0; m_vld = 0;
      return;
    end
    if (!in_valid) begin
      m_vld = 0;
      return;
    end
    a = int'(in_signal);
    if (a < 0) a = -a;
    if (a > 32767) a = 32767;
    dec = m_env - (m_env >> decay_shift);
    en  = (a > dec) ? a : dec;
    m_out = bypass ? int'(in_signal) : ((int'(in_signal) * m_gain) >>> 15);
    m_vld = 1;
    case (m_st)
      M_CLOSED: if (en >= int'(thresh_open)) m_st = M_ATTACK;
      M_ATTACK: begin
        m_gain = m_gain + ATK;
        if (m_gain >= UNITY) begin
          m_gain = UNITY;
          m_st   = M_OPEN;
        end
      end
      M_OPEN: if (en < int'(thresh_close)) begin
        if (int'(hold_len) == 0) m_st = M_RELEASE;
        else begin
          m_st  = M_HOLD;
          m_cnt = int'(hold_len);
        end
      end
      M_HOLD: begin
        if (en >= int'(thresh_open)) m_st = M_OPEN;
        else if (m_cnt == 1) m_st = M_RELEASE;
        else m_cnt = m_cnt - 1;
      end
      default: begin
        if (en >= int'(thresh_open)) m_st = M_ATTACK;
        else begin
          m_gain = m_gain - REL;
          if (m_gain <= 0) begin
            m_gain = 0;
            m_st   = M_CLOSED;
          end
        end
      end
    endcase
    m_env = en;
  endtask

  task automatic step(input logic v, input int s);
    @(negedge clk);
    in_valid  = v;
    in_signal = W'(s);
    @(posedge clk);
    model_edge();
    #1;
    check("out_valid", int'(out_valid), m_vld);
    check("gate_open", int'(gate_open), (m_st != M_CLOSED) ? 1 : 0);
    check("out_signal", int'(out_signal), m_out);
  endtask

  initial begin
    int amp, sig;
    rst = 1'b1; in_valid = 1'b0; in_signal = '0;
    thresh_open = 16'd1000; thresh_close = 16'd500; hold_len = 16'd3;
    decay_shift = 4'd0; bypass = 1'b0;
    m_env = 0; m_gain = 0; m_cnt = 0; m_st = M_CLOSED; m_out = 0; m_vld = 0;

    step(1'b0, 0);
    step(1'b1, 4000);
    check("reset_out", int'(out_signal), 0);
    check("reset_vld", int'(out_valid), 0);
    check("reset_gate", int'(gate_open), 0);
    rst = 1'b0;

    // Below threshold
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 100);
      check("below_out", int'(out_signal), 0);
      check("below_gate", int'(gate_open), 0);
    end

    // Attack ramp
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 4000);
      check("attack_out", int'(out_signal), exp_att[i]);
      check("attack_gate", int'(gate_open), 1);
    end

    // Hold then release
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 200);
      check("release_out", int'(out_signal), exp_rel[i]);
      check("release_gate", int'(gate_open), (i < 5) ? 1 : 0);
    end

    // Hold retrigger: reopen, enter HOLD, count down to 2, then a loud sample
    for (int i = 0; i < 6; i++) step(1'b1, 4000);
    step(1'b1, 200);
    step(1'b1, 200);
    step(1'b1, 4000);
    check("retrig_out", int'(out_signal), 4000);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 200);
      check("retrig_hold_out", int'(out_signal), 200);
      check("retrig_gate", int'(gate_open), 1);
    end

    // Most negative sample at unity gain
    step(1'b1, -32768);
    check("minval_out", int'(out_signal), -32768);
    check("minval_env", int'(dut.env_q), 32767);

    // in_valid gaps freeze everything
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1234);
      check("gap_vld", int'(out_valid), 0);
      check("gap_hold_out", int'(out_signal), -32768);
    end
    step(1'b1, -32768);
    check("after_gap_out", int'(out_signal), -32768);

    // Bypass while closed
    rst = 1'b1;
    step(1'b1, 4000);
    rst = 1'b0;
    bypass = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, byp_in[i]);
      check("bypass_out", int'(out_signal), byp_in[i]);
      check("bypass_gate", int'(gate_open), 0);
    end
    bypass = 1'b0;

    // Reset mid-OPEN
    for (int i = 0; i < 6; i++) step(1'b1, 4000);
    check("preopen_gate", int'(gate_open), 1);
    rst = 1'b1;
    step(1'b1, 4000);
    check("midrst_out", int'(out_signal), 0);
    check("midrst_vld", int'(out_valid), 0);
    check("midrst_gate", int'(gate_open), 0);
    rst = 1'b0;
    step(1'b1, 4000);
    check("postrst_out", int'(out_signal), 0);

    // Randomized traffic
    amp = 200;
    for (int i = 0; i < 800; i++) begin
      if (i % 25 == 0) begin
        case ($urandom_range(0, 3))
          0: amp = 200;
          1: amp = 3000;
          2: amp = 12000;
          default: amp = 32768;
        endcase
      end
      if ($urandom_range(0, 15) == 0) begin
        thresh_open  = W'($urandom_range(0, 6000));
        thresh_close = W'($urandom_range(0, 6000));
        hold_len     = HW'($urandom_range(0, 6));
        decay_shift  = 4'($urandom_range(0, 15));
      end
      bypass = ($urandom_range(0, 19) == 0);
      rst    = ($urandom_range(0, 149) == 0);
      sig = $urandom_range(0, 2 * amp) - amp;
      if (sig > 32767) sig = 32767;
      step($urandom_range(0, 3) != 0, sig);
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
